dmem_responder: RTL

Data-memory responder for the simple processor: the slave end of the `dmem_*` request/acknowledge interface driven by the processor's load/store unit. It accepts one request at a time and performs a word write or read on an internal register-array memory. It returns read data with a single-cycle acknowledge after a fixed, parameterised latency. It sits between the core and the data store in the top level, and serves as the bus-functional memory in core-level benches.

---
 rtl/dmem_responder.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding slave for the dmem_* request/ack
// interface. Stores commit on the acceptance edge. Every access gets a
// one-cycle ack LATENCY edges after acceptance. In-range loads return the
// memory word with that ack.
module dmem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  dmem_req_i,
    input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
    input  logic                  dmem_we_i,
    input  logic [DATA_WIDTH-1:0] dmem_wdata_i,
    output logic [DATA_WIDTH-1:0] dmem_rdata_o,
    output logic                  dmem_ack_o,
    output logic                  dmem_err_o
);

    localparam int IDX_WIDTH = ADDR_WIDTH - 2;
    localparam int MEM_AW    = $clog2(DEPTH);
    // The wait counter only has to hold LATENCY-2.
    localparam int CNT_WIDTH = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_INIT =
        (LATENCY >= 2) ? CNT_WIDTH'(LATENCY - 2) : '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t                 state_reg, state_next;
    logic [CNT_WIDTH-1:0]   cnt_reg, cnt_next;
    logic                   we_reg;
    logic [MEM_AW-1:0]      idx_reg;
    logic                   oor_reg;
    logic                   ack_reg;
    logic                   err_reg;
    logic                   load_ok_reg;
    logic [DATA_WIDTH-1:0]  rd_word_reg;

    logic [DATA_WIDTH-1:0]  mem [DEPTH];

    logic [IDX_WIDTH-1:0]   idx_in;
    logic [MEM_AW-1:0]      mem_idx_in;
    logic                   oor_in;
    logic                   accept;
    logic [MEM_AW-1:0]      rd_idx;
    logic                   sel_oor;
    logic                   sel_load_ok;
    logic                   unused_addr_bits;

    assign idx_in           = dmem_addr_i[ADDR_WIDTH-1:2];
    assign mem_idx_in       = idx_in[MEM_AW-1:0];
    assign unused_addr_bits = ^dmem_addr_i[1:0];

    // DEPTH is a power of two, so the full index is out of range exactly
    // when any bit above the memory address field is set (no aliasing).
    generate
        if (IDX_WIDTH > MEM_AW) begin : g_range
            assign oor_in = |idx_in[IDX_WIDTH-1:MEM_AW];
        end else begin : g_no_range
            assign oor_in = 1'b0;
        end
    endgenerate

    assign accept = (state_reg == S_IDLE) && dmem_req_i;

    // With LATENCY=1 the ACK-entry edge is the acceptance edge itself, so
    // the read must use the live inputs. Otherwise it uses the captured copy.
    assign rd_idx      = (state_reg == S_IDLE) ? mem_idx_in : idx_reg;
    assign sel_oor     = (state_reg == S_IDLE) ? oor_in : oor_reg;
    assign sel_load_ok = (state_reg == S_IDLE) ? (!dmem_we_i && !oor_in)
                                               : (!we_reg && !oor_reg);

    // Next-state and wait-counter logic
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        unique case (state_reg)
            S_IDLE: begin
                if (dmem_req_i) begin
                    if (LATENCY == 1) begin
                        state_next = S_ACK;
                    end else begin
                        state_next = S_WAIT;
                        cnt_next   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_reg == '0) begin
                    state_next = S_ACK;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            S_ACK: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State, captured request and output flags; ack/err only live in ACK
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            we_reg      <= 1'b0;
            idx_reg     <= '0;
            oor_reg     <= 1'b0;
            ack_reg     <= 1'b0;
            err_reg     <= 1'b0;
            load_ok_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                we_reg  <= dmem_we_i;
                idx_reg <= mem_idx_in;
                oor_reg <= oor_in;
            end
            ack_reg     <= (state_next == S_ACK);
            err_reg     <= (state_next == S_ACK) && sel_oor;
            load_ok_reg <= (state_next == S_ACK) && sel_load_ok;
        end
    end

    // Memory write port: stores commit on the acceptance edge when in range
    always_ff @(posedge clk_i) begin
        if (rst_ni && accept && dmem_we_i && !oor_in) begin
            mem[mem_idx_in] <= dmem_wdata_i;
        end
    end

    // Registered read port, free-running; masked by load_ok_reg at the output
    always_ff @(posedge clk_i) begin
        rd_word_reg <= mem[rd_idx];
    end

    assign dmem_ack_o   = ack_reg;
    assign dmem_err_o   = err_reg;
    assign dmem_rdata_o = load_ok_reg ? rd_word_reg : '0;

endmodule
